// File: rtl/mdr_memory_port_pkg.sv
// mdr_memory_port_pkg: shared state encodings and width defaults for the MDR memory port.
package mdr_memory_port_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_e;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 9;
endpackage

// File: rtl/mdr_memory_port_fsm.sv
// mdr_memory_port_fsm: request/acknowledge handshake with timeout for single-word memory accesses.
module mdr_memory_port_fsm
    import mdr_memory_port_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic clear,
    input  logic Read,
    input  logic Write,
    input  logic mem_ack,
    output logic mem_req,
    output logic mem_we,
    output logic busy,
    output logic done,
    output logic err,
    output logic rd_ack
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic err_q, err_d;
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (Read || Write) begin
                    state_d = Read ? RD : WR;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            RD, WR: begin
                // an ack on the expiry edge still completes the transaction
                if (mem_ack) state_d = DONE;
                else if (cnt_q == LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else cnt_d = cnt_q + 1'b1;
            end
            DONE: state_d = IDLE;
        endcase
    end
    assign mem_req = (state_q == RD) || (state_q == WR);
    assign mem_we  = state_q == WR;
    assign busy    = state_q != IDLE;
    assign done    = state_q == DONE;
    assign err     = err_q;
    assign rd_ack  = (state_q == RD) && mem_ack;
endmodule

// File: rtl/mdr_memory_port.sv
// mdr_memory_port: MAR/MDR registers and memory-access stage feeding the MDR input of the bus mux.
module mdr_memory_port
    import mdr_memory_port_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] BusMuxIn_MDR,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic rd_ack;
    mdr_memory_port_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
        .clock   (clock),
        .clear   (clear),
        .Read    (Read),
        .Write   (Write),
        .mem_ack (mem_ack),
        .mem_req (mem_req),
        .mem_we  (mem_we),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .rd_ack  (rd_ack)
    );
    // bus loads are locked out while busy so memory sees stable MAR/MDR
    always_comb begin
        mar_d = (MARin && !busy) ? BusMuxOut[ADDR_W-1:0] : mar_q;
        mdr_d = rd_ack ? mem_rdata : (MDRin && !busy) ? BusMuxOut : mdr_q;
    end
    always_ff @(posedge clock) begin
        if (clear) begin
            mar_q <= '0;
            mdr_q <= '0;
        end else begin
            mar_q <= mar_d;
            mdr_q <= mdr_d;
        end
    end
    assign mem_addr     = mar_q;
    assign mem_wdata    = mdr_q;
    assign BusMuxIn_MDR = mdr_q;
endmodule
